// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: walks one active-low anode per slot,
// with per-slot dead time, leading-zero suppression and a per-frame input snapshot.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [4*NUM_DIGITS-1:0] i_digit,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_enable,
   input  logic                    i_lz_suppress,
   output logic [NUM_DIGITS-1:0]   o_AN,
   output logic [6:0]              o_A2G,
   output logic                    o_DP,
   output logic                    o_frame_start
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           pre;
   logic [IW-1:0]           idx;
   logic                    armed;
   logic [4*NUM_DIGITS-1:0] snap_digit;
   logic [NUM_DIGITS-1:0]   snap_dp;
   logic [NUM_DIGITS-1:0]   snap_en;
   logic                    snap_lz;

   logic                    slot_end;
   logic                    frame_wrap;
   logic                    take_snap;
   logic [NUM_DIGITS-1:0]   zero_from;
   logic [3:0]              nib;
   logic [6:0]              seg;
   logic                    shown;
   logic                    lit;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'b0000001;
         4'h1: decode = 7'b1001111;
         4'h2: decode = 7'b0010010;
         4'h3: decode = 7'b0000110;
         4'h4: decode = 7'b1001100;
         4'h5: decode = 7'b0100100;
         4'h6: decode = 7'b0100000;
         4'h7: decode = 7'b0001111;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0000100;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b1100000;
         4'hC: decode = 7'b0110001;
         4'hD: decode = 7'b1000010;
         4'hE: decode = 7'b0110000;
         4'hF: decode = 7'b0111000;
      endcase
   endfunction

   assign slot_end   = (pre == PRE_LAST);
   assign frame_wrap = slot_end && (idx == IDX_LAST);
   // The first edge out of reset captures inputs so frame 0 is not stale.
   assign take_snap  = !armed || frame_wrap;

   // zero_from[k]: every nibble from k up to the leftmost digit is zero
   always_comb begin
      zero_from = '0;
      zero_from[NUM_DIGITS-1] = (snap_digit[4*NUM_DIGITS-1 -: 4] == 4'h0);
      for (int k = NUM_DIGITS - 2; k >= 0; k--)
         zero_from[k] = zero_from[k+1] && (snap_digit[4*k +: 4] == 4'h0);
   end

   assign nib   = snap_digit[{idx, 2'b00} +: 4];
   assign seg   = decode(nib);
   assign shown = snap_en[idx] && !(snap_lz && (idx != '0) && zero_from[idx]);
   assign lit   = shown && (pre >= PRE_BLANK);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= slot_end ? '0 : pre + 1'b1;
         if (slot_end)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         armed         <= 1'b0;
         snap_digit    <= '0;
         snap_dp       <= '0;
         snap_en       <= '0;
         snap_lz       <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         armed         <= 1'b1;
         o_frame_start <= take_snap;
         if (take_snap) begin
            snap_digit <= i_digit;
            snap_dp    <= i_dp;
            snap_en    <= i_enable;
            snap_lz    <= i_lz_suppress;
         end
      end
   end

   // Registered outputs: one-hot-low anode can never overlap between slots.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_AN  <= '1;
         o_A2G <= '1;
         o_DP  <= 1'b1;
      end else begin
         o_AN  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
         o_A2G <= lit ? seg : '1;
         o_DP  <= lit ? ~snap_dp[idx] : 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: frame-level reference model plus
// hand-computed frame expectations, then randomized inputs and resets.
module tb_seg7_scan_driver;

   localparam int ND  = 4;
   localparam int DIV = 8;
   localparam int BLK = 2;

   logic          i_clk = 1'b0;
   logic          i_reset_n;
   logic [15:0]   i_digit;
   logic [3:0]    i_dp;
   logic [3:0]    i_enable;
   logic          i_lz_suppress;
   logic [3:0]    o_AN;
   logic [6:0]    o_A2G;
   logic          o_DP;
   logic          o_frame_start;

   int n_cmp = 0;
   int n_err = 0;

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_digit(i_digit), .i_dp(i_dp),
      .i_enable(i_enable), .i_lz_suppress(i_lz_suppress), .o_AN(o_AN),
      .o_A2G(o_A2G), .o_DP(o_DP), .o_frame_start(o_frame_start));

   always #5 i_clk = ~i_clk;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: t counts edges since reset release; slot/phase follow by division.
   int         t;
   logic [15:0] s_dig;
   logic [3:0]  s_dp, s_en;
   logic        s_lz;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_fs;

   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         t <= 0; s_dig <= '0; s_dp <= '0; s_en <= '0; s_lz <= 1'b0;
         e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
      end else begin
         int slot, ph;
         bit show, snap;
         slot = (t / DIV) % ND;
         ph   = t % DIV;
         show = s_en[slot] && !(s_lz && slot != 0 && (s_dig >> (4 * slot)) == 16'h0);
         if (show && ph >= BLK) begin
            e_an  <= 4'hF & ~(4'h1 << slot);
            e_seg <= seg_tab[(s_dig >> (4 * slot)) & 16'hF];
            e_dp  <= ~s_dp[slot];
         end else begin
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1;
         end
         snap = (t == 0) || (t % (DIV * ND) == DIV * ND - 1);
         e_fs <= snap;
         if (snap) begin
            s_dig <= i_digit; s_dp <= i_dp; s_en <= i_enable; s_lz <= i_lz_suppress;
         end
         t <= t + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic step();
      @(negedge i_clk);
      #1;
      chk("model_an", o_AN, e_an);
      chk("model_a2g", o_A2G, e_seg);
      chk("model_dp", o_DP, e_dp);
      chk("model_fs", o_frame_start, e_fs);
   endtask

   // Starts on the cycle after a wrap pulse; next-frame inputs go in just before the wrap edge.
   task automatic check_frame(input logic [3:0][3:0] an, input logic [3:0][6:0] sg,
                              input logic [3:0] dp, input int chg_n, input logic [15:0] chg_v,
                              input logic [15:0] nd, input logic [3:0] nen,
                              input logic [3:0] ndp, input logic nlz);
      for (int n = 1; n <= 32; n++) begin
         int s;
         step();
         s = (n - 1) / DIV;
         if (n % DIV == 1) begin
            chk("blank_an", o_AN, 4'hF);
            chk("blank_a2g", o_A2G, 7'h7F);
         end
         if (n % DIV == 3) begin
            chk($sformatf("slot%0d_an", s), o_AN, an[s]);
            chk($sformatf("slot%0d_a2g", s), o_A2G, sg[s]);
            chk($sformatf("slot%0d_dp", s), o_DP, dp[s]);
         end
         if (n == 32) chk("fs_period", o_frame_start, 1'b1);
         if (n == chg_n) i_digit = chg_v;
         if (n == 31) begin
            i_digit = nd; i_enable = nen; i_dp = ndp; i_lz_suppress = nlz;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int rlow;
      bit got_fs;
      i_reset_n = 1'b0;
      i_digit = 16'h12AF; i_enable = 4'hF; i_dp = 4'h0; i_lz_suppress = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_an", o_AN, 4'hF);
      chk("reset_a2g", o_A2G, 7'h7F);
      chk("reset_dp", o_DP, 1'b1);
      chk("reset_fs", o_frame_start, 1'b0);
      step();
      i_reset_n = 1'b1;

      got_fs = 0;
      for (int i = 0; i < 4 && !got_fs; i++) begin
         step();
         got_fs = o_frame_start;
      end
      if (!got_fs) begin
         n_cmp++; n_err++;
         $display("FAIL first_fs: got no pulse expected pulse within 4 cycles");
      end
      repeat (31) step();
      chk("fs_first_wrap", o_frame_start, 1'b1);

      check_frame({4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'hF,
                  0, 16'h0, 16'h1234, 4'hF, 4'h0, 1'b0);
      check_frame({4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF,
                  10, 16'h5678, 16'h5678, 4'hF, 4'h0, 1'b0);
      check_frame({4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'hF,
                  0, 16'h0, 16'h0050, 4'hF, 4'h0, 1'b1);
      check_frame({4'b1111, 4'b1111, 4'b1101, 4'b1110},
                  {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'hF,
                  0, 16'h0, 16'h0000, 4'hF, 4'h0, 1'b1);
      check_frame({4'b1111, 4'b1111, 4'b1111, 4'b1110},
                  {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'hF,
                  0, 16'h0, 16'h8888, 4'b1011, 4'b0001, 1'b0);
      check_frame({4'b0111, 4'b1111, 4'b1101, 4'b1110},
                  {7'b0000000, 7'h7F, 7'b0000000, 7'b0000000}, 4'b1110,
                  0, 16'h0, 16'h12AF, 4'hF, 4'h0, 1'b0);

      // Asynchronous reset in the middle of a lit slot 2.
      repeat (20) step();
      @(posedge i_clk);
      #3;
      chk("pre_reset_an", o_AN, 4'b1011);
      i_reset_n = 1'b0;
      #1;
      chk("async_rst_an", o_AN, 4'hF);
      chk("async_rst_a2g", o_A2G, 7'h7F);
      chk("async_rst_dp", o_DP, 1'b1);
      repeat (3) step();
      i_reset_n = 1'b1;

      rlow = 0;
      repeat (3000) begin
         int tmp;
         step();
         if (rlow > 0) begin
            rlow--;
            if (rlow == 0) i_reset_n = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            i_reset_n = 1'b0;
            rlow = $urandom_range(1, 3);
         end
         if ($urandom_range(0, 15) == 0) begin
            tmp = $urandom_range(0, 65535);
            i_digit = 16'(tmp >> (4 * $urandom_range(0, 4)));
            i_enable = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            i_dp = 4'($urandom);
            i_lz_suppress = 1'($urandom);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (range 1..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (minimum 2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, dead-time cycles at the start of each slot; BLANK_CYCLES < REFRESH_DIV SHALL hold.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port i_digit, input, 4*NUM_DIGITS, hex nibbles; digit k = i_digit[4k+3:4k]; k=0 rightmost.
REQ-007 SHALL have port i_dp, input, NUM_DIGITS, decimal point request per digit (1 = lit).
REQ-008 SHALL have port i_enable, input, NUM_DIGITS, per-digit enable (0 = digit dark).
REQ-009 SHALL have port i_lz_suppress, input, 1, leading-zero suppression mode.
REQ-010 SHALL have port o_AN, output, NUM_DIGITS, anodes, active-low; bit k drives digit k.
REQ-011 SHALL have port o_A2G, output, 7, segments a..g on bits [6:0], active-low.
REQ-012 SHALL have port o_DP, output, 1, decimal point, active-low.
REQ-013 SHALL have port o_frame_start, output, 1, one-cycle pulse on each input snapshot.

Function
REQ-014 SHALL keep prescaler pre counting 0..REFRESH_DIV-1, wrapping to 0.
REQ-015 SHALL advance slot index idx when pre = REFRESH_DIV-1; idx wraps NUM_DIGITS-1 -> 0.
REQ-016 SHALL snapshot i_digit, i_dp, i_enable and i_lz_suppress on the first edge after reset release and on every edge where idx wraps to 0; all display decisions use only the snapshot.
REQ-017 SHALL assert o_frame_start for exactly the cycle after each snapshot edge.
REQ-018 SHALL register o_AN, o_A2G and o_DP; they reflect (idx, pre) of the preceding cycle (1-cycle latency).
REQ-019 SHALL blank during pre < BLANK_CYCLES: o_AN all 1, o_A2G 7'b1111111, o_DP 1.
REQ-020 SHALL otherwise drive o_AN = all 1 except bit idx = 0, provided digit idx is shown.
REQ-021 SHALL treat digit idx as not shown when its snapshot enable = 0, or when lz_suppress = 1, idx != 0, and nibbles idx..NUM_DIGITS-1 are all zero; a not-shown digit behaves as REQ-019 for the whole slot.
REQ-022 SHALL decode 0..F: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
REQ-023 SHALL drive o_DP = ~snapshot_dp[idx] while digit idx is shown.
REQ-024 SHALL not glitch o_AN: at most one bit low in any cycle.

Reset
REQ-025 SHALL, while i_reset_n = 0, force o_AN all 1, o_A2G 7'b1111111, o_DP 1, o_frame_start 0, pre 0, idx 0, and snapshot all 0, independent of i_clk.
REQ-026 SHALL apply REQ-025 immediately on reset assertion mid-slot or mid-frame, and resume at idx 0, pre 0 after release.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-027 Reset: drop i_reset_n mid slot 2 between clock edges -> o_AN=1111, o_A2G=1111111, o_DP=1 without a clock edge.
REQ-028 Decode/scan: i_digit=16'h12AF, i_enable=1111, i_lz_suppress=0 -> slot0 AN=1110 A2G=0111000, slot1 AN=1101 A2G=0001000, slot2 AN=1011 A2G=0010010, slot3 AN=0111 A2G=1001111; each slot 2 blank then 6 lit cycles; o_frame_start period 32 cycles.
REQ-029 Snapshot: change i_digit from 16'h1234 to 16'h5678 during slot 1 -> remainder of frame still shows 1234; 5678 appears only after next o_frame_start.
REQ-030 Leading zero: i_lz_suppress=1, i_digit=16'h0050 -> slots 3,2 dark; slot1 A2G=0100100; slot0 A2G=0000001. i_digit=16'h0000 -> only slot0 lit showing 0.
REQ-031 Enable/DP: i_enable=1011, i_dp=0001, i_digit=16'h8888 -> slot2 AN=1111 whole slot; o_DP=0 only during slot0 lit cycles.
